// File: rtl/scene_pkg.sv
// rtl/scene_pkg.sv - shared constants, encodings and sheet addressing for the selection scene
package scene_pkg;

  localparam int ID_W     = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [11:0] COLOR_TRANSP = 12'h0F0;
  localparam logic [11:0] COLOR_BG     = 12'h878;
  localparam logic [11:0] COLOR_HILITE = 12'hDD3;

  typedef enum logic {
    ST_BROWSE = 1'b0,
    ST_HOLD   = 1'b1
  } scene_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Sheet word address of sprite pixel (px,py); sprites are packed row-major across the sheet.
  function automatic int sprite_addr(input int id, input int px, input int py,
                                     input int sheet_w, input int img_len);
    int per_row;
    per_row = sheet_w / img_len;
    return (py + (id / per_row) * img_len) * sheet_w + px + (id % per_row) * img_len;
  endfunction

endpackage

// File: rtl/grid_tile_locator.sv
// rtl/grid_tile_locator.sv - maps a screen position onto grid column/row, tile and border windows
module grid_tile_locator
  import scene_pkg::*;
#(
  parameter int GRID_COLS  = 4,
  parameter int GRID_ROWS  = 2,
  parameter int GRID_H0    = 40,
  parameter int GRID_V0    = 80,
  parameter int TILE_PITCH = 160,
  parameter int TILE_LEN   = 128,
  parameter int BORDER_W   = 4
) (
  input  logic [9:0]      h_cnt,
  input  logic [9:0]      v_cnt,
  output logic [ID_W-1:0] col,
  output logic [ID_W-1:0] row,
  output logic            in_tile,
  output logic            in_border,
  output logic [9:0]      dx,
  output logic [9:0]      dy
);

  logic [GRID_COLS-1:0] col_tile_hit;
  logic [GRID_COLS-1:0] col_ring_hit;
  logic [GRID_ROWS-1:0] row_tile_hit;
  logic [GRID_ROWS-1:0] row_ring_hit;
  int                   org_h;
  int                   org_v;

  for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
    localparam int ORG = GRID_H0 + c * TILE_PITCH;
    assign col_tile_hit[c] = (int'(h_cnt) >= ORG) && (int'(h_cnt) < ORG + TILE_LEN);
    assign col_ring_hit[c] = (int'(h_cnt) >= ORG - BORDER_W) && (int'(h_cnt) < ORG + TILE_LEN + BORDER_W);
  end

  for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
    localparam int ORG = GRID_V0 + r * TILE_PITCH;
    assign row_tile_hit[r] = (int'(v_cnt) >= ORG) && (int'(v_cnt) < ORG + TILE_LEN);
    assign row_ring_hit[r] = (int'(v_cnt) >= ORG - BORDER_W) && (int'(v_cnt) < ORG + TILE_LEN + BORDER_W);
  end

  // Rings of neighbouring tiles never overlap, so at most one bit of each ring vector is set.
  always_comb begin
    col   = '0;
    row   = '0;
    org_h = GRID_H0;
    org_v = GRID_V0;
    for (int i = 0; i < GRID_COLS; i++) begin
      if (col_ring_hit[i]) begin
        col   = ID_W'(i);
        org_h = GRID_H0 + i * TILE_PITCH;
      end
    end
    for (int j = 0; j < GRID_ROWS; j++) begin
      if (row_ring_hit[j]) begin
        row   = ID_W'(j);
        org_v = GRID_V0 + j * TILE_PITCH;
      end
    end
    in_tile   = (|col_tile_hit) && (|row_tile_hit);
    in_border = (|col_ring_hit) && (|row_ring_hit) && !in_tile;
    dx = '0;
    dy = '0;
    if (in_tile) begin
      dx = 10'(int'(h_cnt) - org_h);
      dy = 10'(int'(v_cnt) - org_v);
    end
  end

endmodule

// File: rtl/poke_select_grid.sv
// rtl/poke_select_grid.sv - sprite selection grid: cursor, select handshake and 2-stage pixel pipeline
module poke_select_grid
  import scene_pkg::*;
#(
  parameter int          GRID_COLS    = 4,
  parameter int          GRID_ROWS    = 2,
  parameter int          GRID_H0      = 40,
  parameter int          GRID_V0      = 80,
  parameter int          TILE_PITCH   = 160,
  parameter int          IMG_LEN      = 32,
  parameter int          SCALE_LOG2   = 2,
  parameter int          BORDER_W     = 4,
  parameter int          SHEET_W      = 320,
  parameter logic [11:0] TRANSP_COLOR = COLOR_TRANSP,
  parameter logic [11:0] BG_COLOR     = COLOR_BG,
  parameter logic [11:0] HILITE_COLOR = COLOR_HILITE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [9:0]      h_cnt,
  input  logic [9:0]      v_cnt,
  input  logic            frame_start,
  input  logic            enable,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_sel,
  input  logic [11:0]     poke_mem_vga_data,
  output logic [16:0]     pixel_addr,
  output logic [11:0]     vga_data,
  output logic [ID_W-1:0] cursor_id,
  output logic            sel_valid,
  output logic [ID_W-1:0] sel_id,
  input  logic            sel_ready
);

  localparam int TILE_LEN = IMG_LEN << SCALE_LOG2;

  logic [ID_W-1:0] loc_col, loc_row;
  logic            loc_in_tile, loc_in_border;
  logic [9:0]      loc_dx, loc_dy;

  grid_tile_locator #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS),
    .GRID_H0   (GRID_H0),
    .GRID_V0   (GRID_V0),
    .TILE_PITCH(TILE_PITCH),
    .TILE_LEN  (TILE_LEN),
    .BORDER_W  (BORDER_W)
  ) u_locator (
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .col      (loc_col),
    .row      (loc_row),
    .in_tile  (loc_in_tile),
    .in_border(loc_in_border),
    .dx       (loc_dx),
    .dy       (loc_dy)
  );

  scene_state_t    state;
  logic [ID_W-1:0] cur_col, cur_row, nxt_col, nxt_row;
  logic            pend_valid;
  dir_t            pend_dir;
  dir_t            dir_in;
  logic            dir_any;
  logic            apply_move;
  logic [3:0]      blink_cnt;

  always_comb begin
    dir_any = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)         dir_in = DIR_UP;
    else if (btn_down)  dir_in = DIR_DOWN;
    else if (btn_left)  dir_in = DIR_LEFT;
    else                dir_in = DIR_RIGHT;
  end

  assign apply_move = frame_start && pend_valid;

  always_comb begin
    nxt_col = cur_col;
    nxt_row = cur_row;
    if (apply_move) begin
      case (pend_dir)
        DIR_UP:    nxt_row = (cur_row == '0) ? ID_W'(GRID_ROWS - 1) : cur_row - ID_W'(1);
        DIR_DOWN:  nxt_row = (cur_row == ID_W'(GRID_ROWS - 1)) ? '0 : cur_row + ID_W'(1);
        DIR_LEFT:  nxt_col = (cur_col == '0) ? ID_W'(GRID_COLS - 1) : cur_col - ID_W'(1);
        DIR_RIGHT: nxt_col = (cur_col == ID_W'(GRID_COLS - 1)) ? '0 : cur_col + ID_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BROWSE;
      cur_col    <= '0;
      cur_row    <= '0;
      cursor_id  <= '0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_UP;
      blink_cnt  <= '0;
      sel_valid  <= 1'b0;
      sel_id     <= '0;
    end else begin
      cur_col   <= nxt_col;
      cur_row   <= nxt_row;
      cursor_id <= ID_W'(int'(nxt_row) * GRID_COLS + int'(nxt_col));
      if (apply_move) pend_valid <= 1'b0;
      case (state)
        ST_BROWSE: begin
          blink_cnt <= '0;
          // Confirm beats any coincident direction; a pulse landing on frame_start refills the slot.
          if (enable && btn_sel) begin
            state      <= ST_HOLD;
            sel_valid  <= 1'b1;
            sel_id     <= cursor_id;
            pend_valid <= 1'b0;
          end else if (enable && dir_any && (!pend_valid || frame_start)) begin
            pend_valid <= 1'b1;
            pend_dir   <= dir_in;
          end
        end
        ST_HOLD: begin
          if (frame_start) blink_cnt <= blink_cnt + 4'd1;
          if (sel_valid && sel_ready) begin
            state     <= ST_BROWSE;
            sel_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  logic            on_screen;
  logic [ID_W-1:0] loc_id;
  logic            blink_on;
  int              addr_full;
  logic            s1_tile, s1_border;

  always_comb begin
    on_screen = (h_cnt < 10'(SCREEN_W)) && (v_cnt < 10'(SCREEN_H));
    loc_id    = ID_W'(int'(loc_row) * GRID_COLS + int'(loc_col));
    blink_on  = (state == ST_BROWSE) || !blink_cnt[3];
    addr_full = sprite_addr(int'(loc_id), int'(loc_dx) >> SCALE_LOG2, int'(loc_dy) >> SCALE_LOG2,
                            SHEET_W, IMG_LEN);
  end

  // Stage 1 issues the ROM address; stage 2 sees its data alongside the stage-1 flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr <= '0;
      s1_tile    <= 1'b0;
      s1_border  <= 1'b0;
      vga_data   <= '0;
    end else begin
      if (on_screen && loc_in_tile) pixel_addr <= 17'(addr_full);
      s1_tile   <= on_screen && loc_in_tile;
      s1_border <= on_screen && loc_in_border && (loc_id == cursor_id) && blink_on;
      if (s1_tile && (poke_mem_vga_data != TRANSP_COLOR)) vga_data <= poke_mem_vga_data;
      else if (s1_border)                                 vga_data <= HILITE_COLOR;
      else                                                vga_data <= BG_COLOR;
    end
  end

endmodule

// File: tb/tb_poke_select_grid.sv
// tb/tb_poke_select_grid.sv - scoreboard bench for poke_select_grid with directed vectors
module tb_poke_select_grid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = '0, v_cnt = '0;
  logic        frame_start = 1'b0, enable = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [11:0] poke_mem_vga_data;
  logic [16:0] pixel_addr;
  logic [11:0] vga_data;
  logic [7:0]  cursor_id;
  logic        sel_valid;
  logic [7:0]  sel_id;
  logic        sel_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_pix[$];
  string       exp_pix_name[$];
  logic [7:0]  exp_sel[$];
  logic        probe = 1'b0, p1 = 1'b0, p2 = 1'b0;

  always #5 clk = ~clk;

  poke_select_grid dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .h_cnt            (h_cnt),
    .v_cnt            (v_cnt),
    .frame_start      (frame_start),
    .enable           (enable),
    .btn_up           (btn_up),
    .btn_down         (btn_down),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .btn_sel          (btn_sel),
    .poke_mem_vga_data(poke_mem_vga_data),
    .pixel_addr       (pixel_addr),
    .vga_data         (vga_data),
    .cursor_id        (cursor_id),
    .sel_valid        (sel_valid),
    .sel_id           (sel_id),
    .sel_ready        (sel_ready)
  );

  function automatic logic [11:0] rom_fn(input logic [16:0] a);
    if (a == 17'd31) return 12'h0F0;
    return 12'(a * 17'd3 + 17'h101);
  endfunction

  assign poke_mem_vga_data = rom_fn(pixel_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    p1 <= probe;
    p2 <= p1;
  end

  // Monitor: pops expectations whenever the DUT presents a probed pixel or a completed handshake.
  always @(negedge clk) begin
    #1;
    if (p2) begin
      if (exp_pix.size() == 0) begin
        checks++; failures++;
        $display("FAIL pix_unexpected actual=%0h expected=none", vga_data);
      end else begin
        check(exp_pix_name.pop_front(), vga_data, exp_pix.pop_front());
      end
    end
    if (sel_valid && sel_ready) begin
      if (exp_sel.size() == 0) begin
        checks++; failures++;
        $display("FAIL sel_unexpected actual=%0h expected=none", sel_id);
      end else begin
        check("sel_handshake_id", sel_id, exp_sel.pop_front());
      end
    end
  end

  task automatic probe_px(input int h, input int v, input logic [11:0] exp);
    @(negedge clk);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    probe = 1'b1;
    exp_pix.push_back(exp);
    exp_pix_name.push_back($sformatf("pix_%0d_%0d", h, v));
    @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic press(input int d);
    @(negedge clk);
    btn_up = (d == 0); btn_down = (d == 1); btn_left = (d == 2); btn_right = (d == 3); btn_sel = (d == 4);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int bad;
    #12;
    check("rst_cursor_id", cursor_id, 0);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_sel_id", sel_id, 0);
    check("rst_pixel_addr", pixel_addr, 0);
    check("rst_vga_data", vga_data, 0);
    @(negedge clk); rst_n = 1'b1; enable = 1'b1;
    frame();

    probe_px(40, 80, rom_fn(17'd0));
    probe_px(10, 10, 12'h878);
    probe_px(47, 85, rom_fn(17'd321));
    probe_px(300, 144, rom_fn(17'd5177));
    probe_px(200, 80, rom_fn(17'd32));
    probe_px(201, 241, rom_fn(17'd160));
    probe_px(639, 80, rom_fn(17'd125));
    probe_px(645, 80, 12'h878);
    probe_px(167, 80, 12'h878);
    probe_px(168, 80, 12'hDD3);
    probe_px(172, 80, 12'h878);
    probe_px(36, 80, 12'hDD3);
    probe_px(35, 80, 12'h878);
    probe_px(40, 76, 12'hDD3);
    probe_px(36, 236, 12'h878);
    repeat (3) @(negedge clk);

    press(2);
    check("move_deferred", cursor_id, 0);
    frame();
    check("left_wrap", cursor_id, 3);
    press(0); frame();
    check("up_wrap", cursor_id, 7);
    press(3); press(3); frame();
    check("right_once_per_frame", cursor_id, 4);
    @(negedge clk); btn_down = 1'b1; btn_right = 1'b1;
    @(negedge clk); btn_down = 1'b0; btn_right = 1'b0;
    frame();
    check("down_beats_right", cursor_id, 0);
    @(negedge clk); btn_left = 1'b1; frame_start = 1'b1;
    @(negedge clk); btn_left = 1'b0; frame_start = 1'b0;
    check("pulse_on_frame_pending", cursor_id, 0);
    frame();
    check("pulse_on_frame_applied", cursor_id, 3);
    enable = 1'b0; press(3); frame(); enable = 1'b1;
    check("enable_low_ignored", cursor_id, 3);
    press(2); frame(); press(2); frame(); press(1); frame();
    check("cursor_at_5", cursor_id, 5);

    @(negedge clk); btn_sel = 1'b1; exp_sel.push_back(8'd5);
    @(negedge clk); btn_sel = 1'b0;
    check("sel_valid_set", sel_valid, 1);
    check("sel_id_set", sel_id, 5);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sel_valid !== 1'b1 || sel_id !== 8'd5) bad++;
      btn_right = (i == 10); btn_left = (i == 25); btn_sel = (i == 20); frame_start = (i == 30);
    end
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right, btn_sel, frame_start} = '0;
    check("hold_stable_50", bad, 0);
    check("hold_buttons_ignored", cursor_id, 5);

    probe_px(196, 240, 12'hDD3);
    repeat (7) frame();
    probe_px(196, 240, 12'h878);
    repeat (8) frame();
    probe_px(196, 240, 12'hDD3);
    repeat (3) @(negedge clk);

    sel_ready = 1'b1;
    @(negedge clk);
    check("sel_valid_drop", sel_valid, 0);
    sel_ready = 1'b0;

    press(4);
    check("hold_again", sel_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel_valid", sel_valid, 0);
    check("async_rst_cursor", cursor_id, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); btn_sel = 1'b1; exp_sel.push_back(8'd0);
    @(negedge clk); btn_sel = 1'b0;
    check("post_rst_sel_id", sel_id, 0);
    sel_ready = 1'b1;
    repeat (2) @(negedge clk);
    sel_ready = 1'b0;
    check("post_rst_release", sel_valid, 0);

    repeat (3) @(negedge clk);
    check("pix_queue_drained", exp_pix.size(), 0);
    check("sel_queue_drained", exp_sel.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
